board_history: RTL and testbench

- Downstream of the touch/scoring stage.
- Captures each completed round (row index, four guessed colours, white and black peg counts) when the scoring stage raises nextRound, and stores it in an 8-row history.
- Tracks game outcome (playing/won/lost).
- Serves registered row reads to the LTM board renderer, which redraws all past guesses every frame.

---
 rtl/board_history.sv | 132 +++++++++++++
 tb/tb_board_history.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/board_history.sv
// Board history for the mastermind game: captures each scored round into an
// 8-row history, tracks whether the game is still being played, won or lost,
// and serves registered row reads to the board renderer.
module board_history #(
  parameter int NUM_ROWS = 8,
  parameter int COLOR_W  = 3,
  parameter int ENTRY_W  = 18
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [$clog2(NUM_ROWS)-1:0] iRow,
  input  logic [COLOR_W-1:0]          iValue01,
  input  logic [COLOR_W-1:0]          iValue02,
  input  logic [COLOR_W-1:0]          iValue03,
  input  logic [COLOR_W-1:0]          iValue04,
  input  logic [2:0]                  iWhitePegs,
  input  logic [2:0]                  iBlackPegs,
  input  logic                        iNextRound,
  input  logic                        iRdEn,
  input  logic [$clog2(NUM_ROWS)-1:0] iRdRow,
  output logic [ENTRY_W-1:0]          oRdData,
  output logic                        oRdValid,
  output logic [NUM_ROWS-1:0]         oRowFilled,
  output logic [3:0]                  oRounds,
  output logic [1:0]                  oGameState,
  output logic                        oCommit,
  output logic                        oErr
);

  typedef enum logic [1:0] {
    PLAYING = 2'd0,
    WON     = 2'd1,
    LOST    = 2'd2
  } gameState_t;

  gameState_t state, stateNext;

  logic                nextRoundPrev;
  logic                commitEvent;
  logic                colorsBad;
  logic                pegsBad;
  logic                rowTaken;
  logic                accept;
  logic                errSet;
  logic [3:0]          pegSum;
  logic [ENTRY_W-1:0]  newEntry;
  logic [ENTRY_W-1:0]  entries [NUM_ROWS];
  logic [NUM_ROWS-1:0] rowFilled;

  // Colour 0 is an empty peg hole and 7 is not a colour, neither may be committed
  function automatic logic badColor(input logic [COLOR_W-1:0] c);
    return (c == '0) || (c == '1);
  endfunction

  // Decide whether the round presented on this cycle is a fresh, legal commit
  always_comb begin
    commitEvent = iNextRound & ~nextRoundPrev;
    colorsBad   = badColor(iValue01) | badColor(iValue02) |
                  badColor(iValue03) | badColor(iValue04);
    pegSum      = {1'b0, iWhitePegs} + {1'b0, iBlackPegs};
    pegsBad     = (pegSum > 4'd4);
    rowTaken    = rowFilled[iRow];
    newEntry    = {iValue04, iValue03, iValue02, iValue01, iWhitePegs, iBlackPegs};
    accept      = commitEvent & ~colorsBad & ~pegsBad & ~rowTaken & (state == PLAYING);
    errSet      = commitEvent & (colorsBad | pegsBad | rowTaken);
  end

  // Game outcome: a four-black round wins even on the last row, otherwise the last row loses
  always_comb begin
    stateNext = state;
    if (accept) begin
      if (iBlackPegs == 3'd4) begin
        stateNext = WON;
      end else if (iRow == '0) begin
        stateNext = LOST;
      end
    end
  end

  // Game state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= PLAYING;
    end else begin
      state <= stateNext;
    end
  end

  // History storage, fill map, round counter and commit/error flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nextRoundPrev <= 1'b0;
      rowFilled     <= '0;
      oRounds       <= 4'd0;
      oCommit       <= 1'b0;
      oErr          <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        entries[i] <= '0;
      end
    end else begin
      nextRoundPrev <= iNextRound;
      oCommit       <= accept;
      if (errSet) begin
        oErr <= 1'b1;
      end
      if (accept) begin
        entries[iRow]   <= newEntry;
        rowFilled[iRow] <= 1'b1;
        if (oRounds != 4'd8) begin
          oRounds <= oRounds + 4'd1;
        end
      end
    end
  end

  // Registered read port; a read of the row being written this cycle sees the new entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oRdData  <= '0;
      oRdValid <= 1'b0;
    end else begin
      oRdValid <= iRdEn;
      if (iRdEn) begin
        oRdData <= (accept && (iRdRow == iRow)) ? newEntry : entries[iRdRow];
      end
    end
  end

  assign oRowFilled = rowFilled;
  assign oGameState = state;

endmodule

// File: tb/tb_board_history.sv
// Randomised and directed bench for board_history: a reference model predicts
// each round's outcome, expected reads and commits are queued, and a monitor
// compares them whenever the design presents them.
module tb_board_history;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  iRow, iValue01, iValue02, iValue03, iValue04;
  logic [2:0]  iWhitePegs, iBlackPegs, iRdRow;
  logic        iNextRound, iRdEn;
  logic [17:0] oRdData;
  logic        oRdValid;
  logic [7:0]  oRowFilled;
  logic [3:0]  oRounds;
  logic [1:0]  oGameState;
  logic        oCommit;
  logic        oErr;

  board_history dut (
    .clock(clock), .reset(reset), .iRow(iRow),
    .iValue01(iValue01), .iValue02(iValue02), .iValue03(iValue03), .iValue04(iValue04),
    .iWhitePegs(iWhitePegs), .iBlackPegs(iBlackPegs), .iNextRound(iNextRound),
    .iRdEn(iRdEn), .iRdRow(iRdRow), .oRdData(oRdData), .oRdValid(oRdValid),
    .oRowFilled(oRowFilled), .oRounds(oRounds), .oGameState(oGameState),
    .oCommit(oCommit), .oErr(oErr)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Reference model of the board: what the history should hold after each edge
  logic [17:0] mEntry [8];
  logic [7:0]  mFilled;
  int          mRounds;
  int          mState;
  logic        mErr;
  logic        mPrev;
  logic        mRdValid;
  logic        started = 1'b0;

  logic [17:0] readQ[$];
  int          commitQ[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mEntry[i] = '0;
    mFilled  = '0;
    mRounds  = 0;
    mState   = 0;
    mErr     = 1'b0;
    mPrev    = 1'b0;
    mRdValid = 1'b0;
    readQ.delete();
    commitQ.delete();
  endtask

  // Drive one cycle of inputs at the falling edge and predict the effect of the next rising edge
  task automatic applyStimulus(input logic nr, input logic [2:0] row,
                               input logic [2:0] v1, input logic [2:0] v2,
                               input logic [2:0] v3, input logic [2:0] v4,
                               input logic [2:0] w, input logic [2:0] b,
                               input logic rd, input logic [2:0] rdRow);
    logic ev, bad;
    @(negedge clock);
    iNextRound = nr; iRow = row;
    iValue01 = v1; iValue02 = v2; iValue03 = v3; iValue04 = v4;
    iWhitePegs = w; iBlackPegs = b; iRdEn = rd; iRdRow = rdRow;
    ev = nr && !mPrev;
    mPrev = nr;
    if (ev) begin
      bad = (v1 == 0) || (v1 == 7) || (v2 == 0) || (v2 == 7) ||
            (v3 == 0) || (v3 == 7) || (v4 == 0) || (v4 == 7) ||
            (int'(w) + int'(b) > 4) || mFilled[row];
      if (bad) begin
        mErr = 1'b1;
      end else if (mState == 0) begin
        mEntry[row] = {v4, v3, v2, v1, w, b};
        mFilled[row] = 1'b1;
        if (mRounds < 8) mRounds++;
        if (b == 3'd4) mState = 1;
        else if (row == 3'd0) mState = 2;
        commitQ.push_back(mRounds);
      end
    end
    mRdValid = rd;
    if (rd) readQ.push_back(mEntry[rdRow]);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    iNextRound = 0; iRow = 0; iValue01 = 0; iValue02 = 0; iValue03 = 0; iValue04 = 0;
    iWhitePegs = 0; iBlackPegs = 0; iRdEn = 0; iRdRow = 0;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Hold nextRound high for several cycles while the renderer reads random rows, then drop it
  task automatic commitRow(input logic [2:0] row, input logic [2:0] v1, input logic [2:0] v2,
                           input logic [2:0] v3, input logic [2:0] v4,
                           input logic [2:0] w, input logic [2:0] b, input int hold);
    for (int i = 0; i < hold; i++) begin
      applyStimulus(1'b1, row, v1, v2, v3, v4, w, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    repeat (2) applyStimulus(1'b0, row, v1, v2, v3, v4, w, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
  endtask

  // Monitor: compare status every cycle and pop expected reads/commits when the design presents them
  always begin
    @(posedge clock);
    #1;
    if (started && !reset) begin
      checkOutput("rowFilled", 32'(oRowFilled), 32'(mFilled));
      checkOutput("rounds", 32'(oRounds), mRounds);
      checkOutput("gameState", 32'(oGameState), mState);
      checkOutput("err", 32'(oErr), 32'(mErr));
      checkOutput("rdValid", 32'(oRdValid), 32'(mRdValid));
      if (oRdValid === 1'b1) begin
        if (readQ.size() == 0) checkOutput("rdUnexpected", 32'd1, 32'd0);
        else checkOutput("rdData", 32'(oRdData), 32'(readQ.pop_front()));
      end
      if (oCommit === 1'b1) begin
        if (commitQ.size() == 0) checkOutput("commitUnexpected", 32'd1, 32'd0);
        else checkOutput("commitRounds", 32'(oRounds), commitQ.pop_front());
      end
    end
  end

  // Directed scenarios followed by randomised games
  initial begin
    logic [2:0] row, v1, v2, v3, v4, w, b;
    reset = 1'b1;
    iNextRound = 0; iRow = 0; iValue01 = 0; iValue02 = 0; iValue03 = 0; iValue04 = 0;
    iWhitePegs = 0; iBlackPegs = 0; iRdEn = 0; iRdRow = 0;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    started = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'(i));

    commitRow(7, 1, 2, 3, 4, 2, 1, 100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    @(posedge clock); #2;
    checkOutput("row7Packed", 32'(oRdData), 32'(18'b100_011_010_001_010_001));
    checkOutput("row7Filled", 32'(oRowFilled), 32'h80);

    commitRow(6, 5, 6, 1, 2, 0, 4, 3);
    commitRow(5, 1, 1, 1, 1, 1, 1, 3);
    @(posedge clock); #2;
    checkOutput("wonState", 32'(oGameState), 32'd1);
    checkOutput("wonRounds", 32'(oRounds), 32'd2);
    checkOutput("wonNoErr", 32'(oErr), 32'd0);

    doReset();
    for (int r = 7; r >= 0; r--) commitRow(3'(r), 3'(r % 6 + 1), 2, 3, 4, 0, 1, 2);
    commitRow(3, 1, 2, 3, 4, 0, 1, 2);
    @(posedge clock); #2;
    checkOutput("lostState", 32'(oGameState), 32'd2);
    checkOutput("lostRounds", 32'(oRounds), 32'd8);

    doReset();
    commitRow(7, 1, 2, 0, 4, 0, 1, 2);
    commitRow(7, 1, 2, 3, 4, 3, 2, 2);
    commitRow(7, 6, 5, 4, 3, 1, 1, 2);
    commitRow(7, 1, 1, 1, 1, 0, 0, 2);
    @(posedge clock); #2;
    checkOutput("rejectErr", 32'(oErr), 32'd1);
    checkOutput("rejectRounds", 32'(oRounds), 32'd1);

    doReset();
    applyStimulus(1, 5, 3, 4, 5, 6, 1, 2, 1, 5);
    applyStimulus(0, 5, 3, 4, 5, 6, 1, 2, 1, 5);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    checkOutput("rdValidAtReset", 32'(oRdValid), 32'd0);
    doReset();

    for (int g = 0; g < 6; g++) begin
      doReset();
      row = 7;
      for (int k = 0; k < 40; k++) begin
        v1 = 3'($urandom_range(1, 6)); v2 = 3'($urandom_range(1, 6));
        v3 = 3'($urandom_range(1, 6)); v4 = 3'($urandom_range(1, 6));
        if ($urandom_range(0, 7) == 0) v2 = 3'($urandom_range(0, 7));
        b = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
        w = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4 - int'(b)));
        if ($urandom_range(0, 5) == 0) row = 3'($urandom_range(0, 7));
        commitRow(row, v1, v2, v3, v4, w, b, int'($urandom_range(1, 5)));
        row = row - 3'd1;
      end
    end

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #2;
    checkOutput("readQDrained", readQ.size(), 32'd0);
    checkOutput("commitQDrained", commitQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
